// File: rtl/texture_load_sequencer_if.sv
// Command, upstream/downstream AXIS and texel-read arbitration signals of the texture load sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface texture_load_sequencer_if #(
   parameter int STREAM_WIDTH   = 32,
   parameter int BEAT_CNT_WIDTH = 16
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [BEAT_CNT_WIDTH-1:0] cmd_beats;
   logic                      s_axis_tvalid;
   logic                      s_axis_tready;
   logic                      s_axis_tlast;
   logic [STREAM_WIDTH-1:0]   s_axis_tdata;
   logic                      m_axis_tvalid;
   logic                      m_axis_tready;
   logic                      m_axis_tlast;
   logic [STREAM_WIDTH-1:0]   m_axis_tdata;
   logic                      rd_req;
   logic                      rd_grant;
   logic                      texture_valid;
   logic                      load_done;
   logic                      load_err;

   modport master (
      output cmd_valid, cmd_beats, s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready, rd_req,
      input  cmd_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, rd_grant,
             texture_valid, load_done, load_err
   );

   modport slave (
      input  cmd_valid, cmd_beats, s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready, rd_req,
      output cmd_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, rd_grant,
             texture_valid, load_done, load_err
   );
endinterface

// File: rtl/texture_load_sequencer.sv
// Texture upload sequencer: blocks texel reads, drains in-flight reads for READ_LATENCY cycles,
// then forwards a counted AXIS burst into the texture buffer with a counter-generated tlast.
module texture_load_sequencer #(
   parameter int STREAM_WIDTH   = 32,
   parameter int BEAT_CNT_WIDTH = 16,
   parameter int READ_LATENCY   = 2
) (
   input  logic                    aclk,
   input  logic                    resetn,
   texture_load_sequencer_if.slave bus
);
   localparam int DW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, STREAM} state_t;

   state_t                    state_q, state_d;
   logic [BEAT_CNT_WIDTH-1:0] beats_q, beats_d;
   logic [DW-1:0]             drain_q, drain_d;
   logic                      tex_valid_q, tex_valid_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic                      beat;

   assign bus.m_axis_tdata  = bus.s_axis_tdata;
   assign bus.texture_valid = tex_valid_q;
   assign bus.load_done     = done_q;
   assign bus.load_err      = err_q;

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         beats_q     <= '0;
         drain_q     <= '0;
         tex_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         drain_q     <= drain_d;
         tex_valid_q <= tex_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      beats_d           = beats_q;
      drain_d           = drain_q;
      tex_valid_d       = tex_valid_q;
      done_d            = 1'b0;
      err_d             = 1'b0;
      beat              = 1'b0;
      bus.cmd_ready     = 1'b0;
      bus.rd_grant      = 1'b0;
      bus.s_axis_tready = 1'b0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tlast  = 1'b0;

      case (state_q)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            // A pending command wins over a texel read in the same cycle.
            bus.rd_grant  = bus.rd_req && tex_valid_q && !bus.cmd_valid;
            if (bus.cmd_valid) begin
               tex_valid_d = 1'b0;
               beats_d     = bus.cmd_beats;
               if (bus.cmd_beats == '0) begin
                  done_d = 1'b1;
               end else begin
                  drain_d = DW'(READ_LATENCY);
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_q <= DW'(1)) begin
               drain_d = '0;
               state_d = STREAM;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         STREAM: begin
            bus.m_axis_tvalid = bus.s_axis_tvalid;
            bus.s_axis_tready = bus.m_axis_tready;
            bus.m_axis_tlast  = (beats_q == BEAT_CNT_WIDTH'(1)) || bus.s_axis_tlast;
            beat              = bus.s_axis_tvalid && bus.m_axis_tready;
            if (beat) begin
               beats_d = beats_q - BEAT_CNT_WIDTH'(1);
               if (beats_q == BEAT_CNT_WIDTH'(1)) begin
                  state_d     = IDLE;
                  tex_valid_d = 1'b1;
                  done_d      = 1'b1;
               end else if (bus.s_axis_tlast) begin
                  // Early upstream tlast: the forwarded tlast rewinds the buffer, texture stays invalid.
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_texture_load_sequencer.sv
// Directed bench for texture_load_sequencer: normal, gated-read, early-tlast, backpressure,
// zero-length and mid-stream reset loads against hand-computed expectations.
module tb_texture_load_sequencer;
   localparam int SW = 32;
   localparam int BW = 16;
   localparam int RL = 2;

   logic aclk   = 1'b0;
   logic resetn = 1'b1;
   always #5 aclk = ~aclk;

   texture_load_sequencer_if #(.STREAM_WIDTH(SW), .BEAT_CNT_WIDTH(BW)) bus ();

   texture_load_sequencer #(
      .STREAM_WIDTH  (SW),
      .BEAT_CNT_WIDTH(BW),
      .READ_LATENCY  (RL)
   ) dut (
      .aclk  (aclk),
      .resetn(resetn),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [SW-1:0] src_d [0:15];
   logic          src_l [0:15];
   logic [SW-1:0] obs_d [0:15];
   logic          obs_l [0:15];
   int            n_obs;
   int            grant_n;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic quiet_inputs();
      bus.cmd_valid     = 1'b0;
      bus.cmd_beats     = '0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.m_axis_tready = 1'b0;
      bus.rd_req        = 1'b0;
   endtask

   task automatic load_src(input logic [SW-1:0] base, input int early_idx);
      for (int i = 0; i < 16; i++) begin
         src_d[i] = base + SW'(i + 1);
         src_l[i] = (i == early_idx);
      end
   endtask

   // Accept cycle followed by the drain cycles; upstream beat 0 is already offered.
   task automatic accept(input logic [BW-1:0] nb, input logic rq);
      @(negedge aclk);
      bus.cmd_valid     = 1'b1;
      bus.cmd_beats     = nb;
      bus.rd_req        = rq;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = src_d[0];
      bus.s_axis_tlast  = src_l[0];
      bus.m_axis_tready = 1'b1;
      #1;
      check("acc_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("acc_rd_grant", 64'(bus.rd_grant), 64'(0));
      check("acc_s_tready", 64'(bus.s_axis_tready), 64'(0));
      check("acc_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      if (nb != '0) begin
         for (int i = 0; i < RL; i++) begin
            @(negedge aclk);
            bus.cmd_valid = 1'b0;
            #1;
            check("drain_cmd_ready", 64'(bus.cmd_ready), 64'(0));
            check("drain_s_tready", 64'(bus.s_axis_tready), 64'(0));
            check("drain_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
            check("drain_rd_grant", 64'(bus.rd_grant), 64'(0));
            check("drain_tex_valid", 64'(bus.texture_valid), 64'(0));
         end
      end
   endtask

   // Runs STREAM until the DUT is back in IDLE (cmd_ready=1); returns in that IDLE cycle.
   task automatic stream(input logic bp, input logic gap, input logic rq);
      int idx;
      bit fin;
      idx = 0;
      fin = 1'b0;
      n_obs = 0;
      grant_n = 0;
      for (int c = 0; c < 200 && !fin; c++) begin
         @(negedge aclk);
         bus.cmd_valid     = 1'b0;
         bus.rd_req        = rq;
         bus.m_axis_tready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         bus.s_axis_tvalid = gap ? (c % 3 != 1) : 1'b1;
         bus.s_axis_tdata  = src_d[idx];
         bus.s_axis_tlast  = src_l[idx];
         #1;
         if (bus.cmd_ready) begin
            fin = 1'b1;
         end else begin
            check("st_s_tready", 64'(bus.s_axis_tready), 64'(bus.m_axis_tready));
            check("st_m_tvalid", 64'(bus.m_axis_tvalid), 64'(bus.s_axis_tvalid));
            if (bus.rd_grant) grant_n++;
            if (bus.m_axis_tvalid && bus.m_axis_tready && n_obs < 16) begin
               obs_d[n_obs] = bus.m_axis_tdata;
               obs_l[n_obs] = bus.m_axis_tlast;
               n_obs++;
               if (idx < 15) idx++;
            end
         end
      end
      check("stream_returns_idle", 64'(fin), 64'(1));
   endtask

   task automatic expect_obs(input string tag, input int n, input int last_idx);
      check({tag, "_beats"}, 64'(n_obs), 64'(n));
      for (int i = 0; i < n && i < n_obs; i++) begin
         check({tag, "_data"}, 64'(obs_d[i]), 64'(src_d[i]));
         check({tag, "_tlast"}, 64'(obs_l[i]), 64'(i == last_idx));
      end
   endtask

   task automatic next_idle_cycle();
      @(negedge aclk);
      quiet_inputs();
      #1;
      check("pulse_done_clear", 64'(bus.load_done), 64'(0));
      check("pulse_err_clear", 64'(bus.load_err), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet_inputs();
      #1 resetn = 1'b0;
      #2;
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("rst_rd_grant", 64'(bus.rd_grant), 64'(0));
      check("rst_s_tready", 64'(bus.s_axis_tready), 64'(0));
      check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      check("rst_m_tlast", 64'(bus.m_axis_tlast), 64'(0));
      check("rst_tex_valid", 64'(bus.texture_valid), 64'(0));
      check("rst_load_done", 64'(bus.load_done), 64'(0));
      check("rst_load_err", 64'(bus.load_err), 64'(0));
      bus.s_axis_tdata = 32'hA5A5_5A5A;
      #1;
      check("tdata_passthru", 64'(bus.m_axis_tdata), 64'h0000_0000_A5A5_5A5A);
      @(negedge aclk);
      resetn = 1'b1;

      // Basic 4-beat load 0x11..0x44
      for (int i = 0; i < 16; i++) begin
         src_d[i] = SW'((i + 1) * 32'h11);
         src_l[i] = 1'b0;
      end
      accept(16'd4, 1'b0);
      stream(1'b0, 1'b0, 1'b0);
      expect_obs("t1", 4, 3);
      check("t1_load_done", 64'(bus.load_done), 64'(1));
      check("t1_load_err", 64'(bus.load_err), 64'(0));
      check("t1_tex_valid", 64'(bus.texture_valid), 64'(1));
      check("t1_excess_s_tready", 64'(bus.s_axis_tready), 64'(0));
      next_idle_cycle();

      // Read gating with rd_req held high over a 3-beat load
      @(negedge aclk);
      bus.rd_req = 1'b1;
      #1;
      check("t2_idle_grant", 64'(bus.rd_grant), 64'(1));
      load_src(32'hA0, -1);
      accept(16'd3, 1'b1);
      stream(1'b0, 1'b0, 1'b1);
      expect_obs("t2", 3, 2);
      check("t2_grant_during_load", 64'(grant_n), 64'(0));
      check("t2_grant_after_last", 64'(bus.rd_grant), 64'(1));
      check("t2_load_done", 64'(bus.load_done), 64'(1));
      next_idle_cycle();

      // Early upstream tlast on beat 3 of 8
      load_src(32'hB0, 2);
      accept(16'd8, 1'b1);
      stream(1'b0, 1'b0, 1'b1);
      expect_obs("t3", 3, 2);
      check("t3_load_err", 64'(bus.load_err), 64'(1));
      check("t3_load_done", 64'(bus.load_done), 64'(0));
      check("t3_tex_valid", 64'(bus.texture_valid), 64'(0));
      check("t3_rd_grant", 64'(bus.rd_grant), 64'(0));
      check("t3_grant_during_load", 64'(grant_n), 64'(0));
      next_idle_cycle();

      // Backpressure 1,0,0,1 with gapped upstream valid
      load_src(32'hC0, -1);
      accept(16'd4, 1'b0);
      stream(1'b1, 1'b1, 1'b0);
      expect_obs("t4", 4, 3);
      check("t4_load_done", 64'(bus.load_done), 64'(1));
      check("t4_tex_valid", 64'(bus.texture_valid), 64'(1));
      next_idle_cycle();

      // Zero-length command with a valid texture present
      accept(16'd0, 1'b0);
      @(negedge aclk);
      bus.cmd_valid     = 1'b0;
      bus.m_axis_tready = 1'b1;
      #1;
      check("t5_load_done", 64'(bus.load_done), 64'(1));
      check("t5_tex_valid", 64'(bus.texture_valid), 64'(0));
      check("t5_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("t5_s_tready", 64'(bus.s_axis_tready), 64'(0));
      check("t5_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      next_idle_cycle();

      // Async reset after 2 of 6 beats, then a clean 2-beat load
      load_src(32'hD0, -1);
      accept(16'd6, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge aclk);
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = src_d[i];
         bus.m_axis_tready = 1'b1;
         #1;
         check("t6_pre_m_tvalid", 64'(bus.m_axis_tvalid), 64'(1));
         check("t6_pre_m_tlast", 64'(bus.m_axis_tlast), 64'(0));
      end
      @(negedge aclk);
      bus.s_axis_tdata = src_d[2];
      #1;
      resetn = 1'b0;
      #1;
      check("t6_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("t6_rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      check("t6_rst_s_tready", 64'(bus.s_axis_tready), 64'(0));
      check("t6_rst_m_tlast", 64'(bus.m_axis_tlast), 64'(0));
      check("t6_rst_tex_valid", 64'(bus.texture_valid), 64'(0));
      @(negedge aclk);
      quiet_inputs();
      resetn = 1'b1;
      load_src(32'hE0, -1);
      accept(16'd2, 1'b0);
      stream(1'b0, 1'b0, 1'b0);
      expect_obs("t6", 2, 1);
      check("t6_load_done", 64'(bus.load_done), 64'(1));
      check("t6_tex_valid", 64'(bus.texture_valid), 64'(1));
      next_idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
